// File: rtl/alu_unit.sv
// C-bus ALU: single-cycle arithmetic/shift ops plus a multi-cycle shift-add multiply,
// sequenced by a start/busy/done handshake with the control unit.
module alu_unit #(
    parameter int WIDTH   = 19,
    parameter int MUL_CYC = 19
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a_bus,
    input  logic [WIDTH-1:0] b_bus,
    input  logic [3:0]       alu_op,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] c_out,
    output logic             z_flag
);

    localparam int CNT_W = (MUL_CYC > 1) ? $clog2(MUL_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_CYC - 1);

    localparam logic [3:0] OP_ADD  = 4'b0001;
    localparam logic [3:0] OP_SUB  = 4'b0010;
    localparam logic [3:0] OP_PSA  = 4'b0011;
    localparam logic [3:0] OP_PSB  = 4'b0100;
    localparam logic [3:0] OP_INC  = 4'b0101;
    localparam logic [3:0] OP_DEC  = 4'b0110;
    localparam logic [3:0] OP_SHR1 = 4'b0111;
    localparam logic [3:0] OP_SHL1 = 4'b1000;
    localparam logic [3:0] OP_SHR2 = 4'b1001;
    localparam logic [3:0] OP_MUL  = 4'b1010;
    localparam logic [3:0] OP_CLR  = 4'b1011;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_MUL  = 1'b1
    } state_t;

    state_t           state;
    state_t           state_next;

    logic [WIDTH-1:0] mplier_a;
    logic [WIDTH-1:0] mcand_b;
    logic [WIDTH-1:0] acc;
    logic [CNT_W-1:0] cnt;

    logic [WIDTH-1:0] sc_result;
    logic             sc_load;
    logic [WIDTH-1:0] acc_sum;
    logic             mul_last;

    logic [WIDTH-1:0] c_next;
    logic             z_next;
    logic             done_next;
    logic             busy_next;
    logic [WIDTH-1:0] mplier_next;
    logic [WIDTH-1:0] mcand_next;
    logic [WIDTH-1:0] acc_next;
    logic [CNT_W-1:0] cnt_next;

    assign acc_sum  = acc + (mcand_b[0] ? mplier_a : '0);
    assign mul_last = (cnt == CNT_LAST);

    // Single-cycle result; sc_load stays low for NOP, MUL and reserved codes so c_out/z_flag hold.
    always_comb begin
        sc_result = '0;
        sc_load   = 1'b0;
        case (alu_op)
            OP_ADD:  begin sc_result = a_bus + b_bus;          sc_load = 1'b1; end
            OP_SUB:  begin sc_result = a_bus - b_bus;          sc_load = 1'b1; end
            OP_PSA:  begin sc_result = a_bus;                  sc_load = 1'b1; end
            OP_PSB:  begin sc_result = b_bus;                  sc_load = 1'b1; end
            OP_INC:  begin sc_result = a_bus + WIDTH'(1);      sc_load = 1'b1; end
            OP_DEC:  begin sc_result = a_bus - WIDTH'(1);      sc_load = 1'b1; end
            OP_SHR1: begin sc_result = a_bus >> 1'b1;          sc_load = 1'b1; end
            OP_SHL1: begin sc_result = a_bus << 1'b1;          sc_load = 1'b1; end
            OP_SHR2: begin sc_result = a_bus >> 2'd2;          sc_load = 1'b1; end
            OP_CLR:  begin sc_result = '0;                     sc_load = 1'b1; end
            default: begin sc_result = '0;                     sc_load = 1'b0; end
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (start && (alu_op == OP_MUL)) begin
                    state_next = S_MUL;
                end else begin
                    state_next = S_IDLE;
                end
            end
            S_MUL: begin
                if (mul_last) begin
                    state_next = S_IDLE;
                end else begin
                    state_next = S_MUL;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Output/datapath next values; start and operands are ignored while multiplying.
    always_comb begin
        c_next      = c_out;
        z_next      = z_flag;
        done_next   = 1'b0;
        busy_next   = busy;
        mplier_next = mplier_a;
        mcand_next  = mcand_b;
        acc_next    = acc;
        cnt_next    = cnt;
        case (state)
            S_IDLE: begin
                if (start) begin
                    if (alu_op == OP_MUL) begin
                        mplier_next = a_bus;
                        mcand_next  = b_bus;
                        acc_next    = '0;
                        cnt_next    = '0;
                        busy_next   = 1'b1;
                    end else begin
                        done_next = 1'b1;
                        if (sc_load) begin
                            c_next = sc_result;
                            z_next = (sc_result == '0);
                        end else begin
                            c_next = c_out;
                            z_next = z_flag;
                        end
                    end
                end else begin
                    done_next = 1'b0;
                end
            end
            S_MUL: begin
                acc_next    = acc_sum;
                mplier_next = mplier_a << 1'b1;
                mcand_next  = mcand_b >> 1'b1;
                cnt_next    = cnt + CNT_W'(1);
                if (mul_last) begin
                    c_next    = acc_sum;
                    z_next    = (acc_sum == '0);
                    busy_next = 1'b0;
                    done_next = 1'b1;
                end else begin
                    busy_next = 1'b1;
                end
            end
            default: begin
                busy_next = 1'b0;
            end
        endcase
    end

    // Registered outputs and multiplier working registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            c_out    <= '0;
            z_flag   <= 1'b0;
            done     <= 1'b0;
            busy     <= 1'b0;
            mplier_a <= '0;
            mcand_b  <= '0;
            acc      <= '0;
            cnt      <= '0;
        end else begin
            c_out    <= c_next;
            z_flag   <= z_next;
            done     <= done_next;
            busy     <= busy_next;
            mplier_a <= mplier_next;
            mcand_b  <= mcand_next;
            acc      <= acc_next;
            cnt      <= cnt_next;
        end
    end

endmodule

// File: tb/tb_alu_unit.sv
// Bench for alu_unit: constant vector table for single-cycle ops, hand sequences for
// multiply, back-to-back starts and resets; results checked through a scoreboard queue.
module tb_alu_unit;

    localparam int W = 19;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] a_bus;
    logic [W-1:0] b_bus;
    logic [3:0]   alu_op;
    logic         start;
    logic         busy;
    logic         done;
    logic [W-1:0] c_out;
    logic         z_flag;

    alu_unit #(.WIDTH(W), .MUL_CYC(19)) dut (
        .clk    (clk),
        .rst    (rst),
        .a_bus  (a_bus),
        .b_bus  (b_bus),
        .alu_op (alu_op),
        .start  (start),
        .busy   (busy),
        .done   (done),
        .c_out  (c_out),
        .z_flag (z_flag)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] c;
        logic         z;
    } vec_t;

    typedef struct {
        logic [W-1:0] c;
        logic         z;
        int           due;
    } exp_t;

    vec_t tbl [16];
    exp_t sb [$];
    int   cyc   = 0;
    int   n_vec = 0;
    int   n_err = 0;

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Monitor: pops the scoreboard on every done pulse and checks handshake invariants.
    initial begin
        logic [W-1:0] prev_c;
        exp_t         e;
        prev_c = '0;
        forever begin
            @(negedge clk);
            if (busy && done) begin
                n_err++;
                $display("FAIL busy_done_overlap: busy=%0b done=%0b, required not both high", busy, done);
            end
            if (rst !== 1'b1 && done !== 1'b1 && c_out !== prev_c) begin
                n_err++;
                $display("FAIL c_out_change_without_done: got %05h, required held %05h", c_out, prev_c);
            end
            if (done === 1'b1) begin
                n_vec++;
                if (sb.size() == 0) begin
                    n_err++;
                    $display("FAIL spurious_done at cycle %0d: c_out=%05h, required no done", cyc, c_out);
                end else begin
                    e = sb.pop_front();
                    if (c_out !== e.c || z_flag !== e.z || cyc != e.due) begin
                        n_err++;
                        $display("FAIL result: got c=%05h z=%0b cycle=%0d, required c=%05h z=%0b cycle=%0d",
                                 c_out, z_flag, cyc, e.c, e.z, e.due);
                    end
                end
            end
            prev_c = c_out;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

    task automatic drive(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] ec, input logic ez, input logic is_mul);
        exp_t e;
        @(negedge clk);
        alu_op = op;
        a_bus  = a;
        b_bus  = b;
        start  = 1'b1;
        e.c    = ec;
        e.z    = ez;
        e.due  = cyc + (is_mul ? 20 : 1);
        sb.push_back(e);
    endtask

    task automatic idle();
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic check_reset(input string name);
        n_vec++;
        if (c_out !== '0 || z_flag !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            n_err++;
            $display("FAIL %s: got c=%05h z=%0b busy=%0b done=%0b, required all zero",
                     name, c_out, z_flag, busy, done);
        end
    endtask

    task automatic mul_seq(input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] ec, input logic ez, input logic noise);
        int nb;
        bit seen;
        nb   = 0;
        seen = 1'b0;
        drive(4'b1010, a, b, ec, ez, 1'b1);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (noise && i < 17) begin
                a_bus  = W'($urandom);
                b_bus  = W'($urandom);
                alu_op = 4'($urandom);
                start  = 1'($urandom);
            end else begin
                start = 1'b0;
            end
            if (busy === 1'b1) nb++;
            if (done === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        n_vec++;
        if (!seen || nb != 19) begin
            n_err++;
            $display("FAIL mul_busy_cycles: got busy=%0d done_seen=%0b, required busy=19 done_seen=1", nb, seen);
        end
    endtask

    initial begin
        bit bad;
        tbl[0]  = '{4'b0001, 19'h7FFFF, 19'h00001, 19'h00000, 1'b1};
        tbl[1]  = '{4'b0010, 19'h00005, 19'h00007, 19'h7FFFE, 1'b0};
        tbl[2]  = '{4'b1001, 19'h00400, 19'h00000, 19'h00100, 1'b0};
        tbl[3]  = '{4'b0011, 19'h12345, 19'h0ABCD, 19'h12345, 1'b0};
        tbl[4]  = '{4'b0100, 19'h12345, 19'h0ABCD, 19'h0ABCD, 1'b0};
        tbl[5]  = '{4'b0111, 19'h40001, 19'h00000, 19'h20000, 1'b0};
        tbl[6]  = '{4'b1000, 19'h40001, 19'h00000, 19'h00002, 1'b0};
        tbl[7]  = '{4'b0110, 19'h00000, 19'h00000, 19'h7FFFF, 1'b0};
        tbl[8]  = '{4'b0000, 19'h00001, 19'h00001, 19'h7FFFF, 1'b0};
        tbl[9]  = '{4'b1011, 19'h12345, 19'h00000, 19'h00000, 1'b1};
        tbl[10] = '{4'b0000, 19'h00000, 19'h00000, 19'h00000, 1'b1};
        tbl[11] = '{4'b0101, 19'h7FFFF, 19'h00000, 19'h00000, 1'b1};
        tbl[12] = '{4'b0001, 19'h01234, 19'h04321, 19'h05555, 1'b0};
        tbl[13] = '{4'b1100, 19'h00001, 19'h00002, 19'h05555, 1'b0};
        tbl[14] = '{4'b0010, 19'h00003, 19'h00003, 19'h00000, 1'b1};
        tbl[15] = '{4'b1101, 19'h00007, 19'h00007, 19'h00000, 1'b1};

        a_bus  = '0;
        b_bus  = '0;
        alu_op = 4'b0000;
        start  = 1'b0;
        rst    = 1'b0;
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        check_reset("reset_state");
        #2 rst = 1'b0;

        for (int i = 0; i < 16; i++) begin
            drive(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].z, 1'b0);
            idle();
        end

        mul_seq(19'd300, 19'd200, 19'd60000, 1'b0, 1'b1);
        mul_seq(19'h40000, 19'h00004, 19'h00000, 1'b1, 1'b0);
        mul_seq(19'h7FFFF, 19'h7FFFF, 19'h00001, 1'b0, 1'b1);
        mul_seq(19'h00ABC, 19'h00123, 19'h433B4, 1'b0, 1'b0);

        // Back-to-back starts: done stays high, one result per cycle.
        drive(4'b0101, 19'h00000, 19'h00000, 19'h00001, 1'b0, 1'b0);
        drive(4'b0101, 19'h00000, 19'h00000, 19'h00001, 1'b0, 1'b0);
        drive(4'b0110, 19'h00000, 19'h00000, 19'h7FFFF, 1'b0, 1'b0);
        drive(4'b1111, 19'h00000, 19'h00000, 19'h7FFFF, 1'b0, 1'b0);
        idle();
        @(negedge clk);

        // Mid-cycle asynchronous reset with a non-zero result on the bus.
        #2 rst = 1'b1;
        #1 check_reset("async_reset_immediate");
        sb.delete();
        @(negedge clk);
        #2 rst = 1'b0;

        // Reset in the middle of a multiply: the aborted op never signals done.
        drive(4'b1010, 19'h00003, 19'h00005, 19'h0000F, 1'b0, 1'b1);
        idle();
        repeat (9) @(negedge clk);
        #2 rst = 1'b1;
        #1 check_reset("reset_mid_mul");
        sb.delete();
        @(negedge clk);
        #2 rst = 1'b0;
        bad = 1'b0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0) bad = 1'b1;
        end
        n_vec++;
        if (bad) begin
            n_err++;
            $display("FAIL aborted_mul_quiet: got done/busy activity after reset, required none");
        end

        drive(4'b0001, 19'h00002, 19'h00003, 19'h00005, 1'b0, 1'b0);
        idle();

        for (int i = 0; i < 60 && sb.size() != 0; i++) @(negedge clk);
        n_vec++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: got %0d pending results, required 0", sb.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
